// File: rtl/axi_r_burst_rr_scheduler.sv
// Burst-locked round-robin scheduler for a shared AXI R channel, with outstanding-burst tracking.
// Optional stall watchdog compiled in with `define AXI_R_SCHED_WATCHDOG_EN.
//
//  state     | meaning
//  ----------+-------------------------------------------------------------
//  ST_IDLE   | no burst owns the output; arbitrate round-robin each cycle
//  ST_LOCKED | lock_idx owns the output until its RLAST beat handshakes
module axi_r_burst_rr_scheduler #(
  parameter int N_INIT_PORT = 4,
  parameter int AUX_W       = 73,
  parameter int ID_W        = 16,
  parameter int OUT_CNT_W   = 10,
  parameter int WDOG_LIMIT  = 256,
  parameter int LOG_N       = $clog2(N_INIT_PORT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_INIT_PORT-1:0]        rvalid_i,
  input  logic [N_INIT_PORT-1:0]        rlast_i,
  input  logic [N_INIT_PORT*ID_W-1:0]   rid_i,
  input  logic [N_INIT_PORT*AUX_W-1:0]  aux_i,
  output logic [N_INIT_PORT-1:0]        rready_o,
  output logic                          rvalid_o,
  output logic                          rlast_o,
  output logic [ID_W-1:0]               rid_o,
  output logic [AUX_W-1:0]              aux_o,
  input  logic                          rready_i,
  output logic [LOG_N-1:0]              sel_idx_o,
  input  logic                          incr_req_i,
  output logic                          outstanding_o,
  output logic                          full_o,
  output logic                          wdog_o
);

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [LOG_N-1:0]       rr_ptr_q, rr_ptr_d;
  logic [LOG_N-1:0]       lock_idx_q, lock_idx_d;
  logic [OUT_CNT_W-1:0]   cnt_q, cnt_d;

  logic                   win_found;
  logic [LOG_N-1:0]       win_idx;
  logic [LOG_N-1:0]       cand_idx;
  int                     cand;
  logic                   route_en;
  logic [LOG_N-1:0]       sel;
  logic                   hs;
  logic                   last_hs;

  // Round-robin search starting just after the last burst's owner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= N_INIT_PORT; k++) begin
      cand     = (int'(rr_ptr_q) + k) % N_INIT_PORT;
      cand_idx = LOG_N'(cand);
      if (!win_found && rvalid_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    route_en = 1'b0;
    sel      = '0;
    if (state_q == ST_LOCKED) begin
      route_en = 1'b1;
      sel      = lock_idx_q;
    end else if (win_found) begin
      route_en = 1'b1;
      sel      = win_idx;
    end
  end

  always_comb begin
    rready_o = '0;
    if (route_en) begin
      rready_o[sel] = rready_i;
    end
    rvalid_o  = route_en & rvalid_i[sel];
    rlast_o   = rvalid_o & rlast_i[sel];
    rid_o     = rvalid_o ? rid_i[sel*ID_W +: ID_W] : '0;
    aux_o     = rvalid_o ? aux_i[sel*AUX_W +: AUX_W] : '0;
    sel_idx_o = sel;
  end

  assign hs      = rvalid_o & rready_i;
  assign last_hs = hs & rlast_o;

  // Any presented beat that does not finish its burst locks the grant so it cannot be revoked.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          if (last_hs) begin
            rr_ptr_d = win_idx;
          end else begin
            state_d    = ST_LOCKED;
            lock_idx_d = win_idx;
          end
        end
      end
      ST_LOCKED: begin
        if (last_hs) begin
          state_d  = ST_IDLE;
          rr_ptr_d = lock_idx_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    case ({incr_req_i, last_hs})
      2'b10:   if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      2'b01:   if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= LOG_N'(N_INIT_PORT - 1);
      lock_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
      cnt_q      <= cnt_d;
    end
  end

  assign outstanding_o = |cnt_q;
  assign full_o        = &cnt_q;

`ifdef AXI_R_SCHED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);

  logic [WDOG_W-1:0] stall_q, stall_d;
  logic              wdog_q, wdog_d;

  // Down-counter reloaded on any handshake or outside LOCKED; reaching zero means WDOG_LIMIT stalls.
  always_comb begin
    stall_d = WDOG_W'(WDOG_LIMIT);
    if (state_q == ST_LOCKED && !hs) begin
      stall_d = (stall_q == '0) ? '0 : stall_q - 1'b1;
    end
    wdog_d = wdog_q | (stall_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= WDOG_W'(WDOG_LIMIT);
      wdog_q  <= 1'b0;
    end else begin
      stall_q <= stall_d;
      wdog_q  <= wdog_d;
    end
  end

  assign wdog_o = wdog_q;
`else
  // Watchdog compiled out: constant 0 (the comparison is always false).
  assign wdog_o = (WDOG_LIMIT < 0);
`endif

endmodule

// File: tb/tb_axi_r_burst_rr_scheduler.sv
// Scoreboard bench for axi_r_burst_rr_scheduler: per-source burst queues, a burst-level
// arbitration model and a monitor that checks every delivered beat and the per-cycle controls.
module tb_axi_r_burst_rr_scheduler;
  localparam int N          = 4;
  localparam int AUX_W      = 73;
  localparam int ID_W       = 16;
  localparam int OUT_CNT_W  = 10;
  localparam int WDOG_LIMIT = 8;
  localparam int LOG_N      = 2;
  localparam int CNT_MAX    = (1 << OUT_CNT_W) - 1;

  typedef struct {
    logic [ID_W-1:0]  id;
    logic [AUX_W-1:0] aux;
    logic             last;
  } beat_t;

  typedef struct {
    int    idx;
    beat_t b;
  } exp_t;

  logic                  clk;
  logic                  rst_n;
  logic [N-1:0]          rvalid_i, rlast_i, rready_o;
  logic [N*ID_W-1:0]     rid_i;
  logic [N*AUX_W-1:0]    aux_i;
  logic                  rvalid_o, rlast_o, rready_i;
  logic [ID_W-1:0]       rid_o;
  logic [AUX_W-1:0]      aux_o;
  logic [LOG_N-1:0]      sel_idx_o;
  logic                  incr_req_i, outstanding_o, full_o, wdog_o;

  axi_r_burst_rr_scheduler #(
    .N_INIT_PORT(N), .AUX_W(AUX_W), .ID_W(ID_W), .OUT_CNT_W(OUT_CNT_W), .WDOG_LIMIT(WDOG_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rvalid_i(rvalid_i), .rlast_i(rlast_i), .rid_i(rid_i),
    .aux_i(aux_i), .rready_o(rready_o), .rvalid_o(rvalid_o), .rlast_o(rlast_o),
    .rid_o(rid_o), .aux_o(aux_o), .rready_i(rready_i), .sel_idx_o(sel_idx_o),
    .incr_req_i(incr_req_i), .outstanding_o(outstanding_o), .full_o(full_o), .wdog_o(wdog_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  beat_t src_q [N][$];
  bit    pres [N];
  exp_t  exp_q [$];
  int    got_idx [$];

  int       m_owner, m_ptr, m_cnt;
  bit       exp_valid;
  logic [N-1:0] exp_rready;
  int       exp_sel, exp_cnt;
  bit       mon_en;
  int       n_tests, n_fail;
  exp_t     mon_e;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add_burst(input int s, input int len);
    beat_t b;
    b.id = ID_W'($urandom());
    for (int k = 0; k < len; k++) begin
      b.aux  = AUX_W'({$urandom(), $urandom(), $urandom()});
      b.last = (k == len - 1);
      src_q[s].push_back(b);
    end
  endtask

  // Present source beats and predict this cycle's outcome from burst-level rules.
  task automatic drive(input bit rr, input bit rand_v, input bit incr);
    int  g;
    int  c;
    bit  gv, hs, last;
    for (int i = 0; i < N; i++)
      if (!pres[i] && src_q[i].size() > 0 && (!rand_v || $urandom_range(1, 0) == 1)) pres[i] = 1'b1;
    rvalid_i = '0; rlast_i = '0; rid_i = '0; aux_i = '0;
    for (int i = 0; i < N; i++) begin
      if (pres[i]) begin
        rvalid_i[i] = 1'b1;
        rlast_i[i]  = src_q[i][0].last;
        rid_i[i*ID_W +: ID_W]    = src_q[i][0].id;
        aux_i[i*AUX_W +: AUX_W]  = src_q[i][0].aux;
      end
    end
    rready_i   = rr;
    incr_req_i = incr;

    g = -1;
    if (m_owner >= 0) g = m_owner;
    else
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (g < 0 && pres[c]) g = c;
      end
    gv         = (g >= 0) && pres[g];
    exp_valid  = gv;
    exp_sel    = (g >= 0) ? g : 0;
    exp_rready = (g >= 0 && rr) ? N'(1 << g) : '0;
    exp_cnt    = m_cnt;
    hs   = gv && rr;
    last = 1'b0;
    if (hs) begin
      exp_t e;
      e.idx = g;
      e.b   = src_q[g][0];
      last  = e.b.last;
      exp_q.push_back(e);
      void'(src_q[g].pop_front());
      pres[g] = 1'b0;
    end
    if (g >= 0) begin
      if (hs && last) begin m_owner = -1; m_ptr = g; end
      else m_owner = g;
    end
    if (incr && !(hs && last)) begin
      if (m_cnt < CNT_MAX) m_cnt++;
    end else if (!incr && hs && last) begin
      if (m_cnt > 0) m_cnt--;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit rr, input bit rand_v, input bit incr);
    drive(rr, rand_v, incr);
    tick();
  endtask

  task automatic do_reset();
    chk("exp_q_drained", 128'(exp_q.size()), 0);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    rvalid_i = '0; rlast_i = '0; rid_i = '0; aux_i = '0; rready_i = 1'b0; incr_req_i = 1'b0;
    for (int i = 0; i < N; i++) begin src_q[i].delete(); pres[i] = 1'b0; end
    m_owner = -1; m_ptr = N - 1; m_cnt = 0;
    exp_valid = 1'b0; exp_rready = '0; exp_sel = 0; exp_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rvalid_o", rvalid_o, 0);
    chk("rst_rready_o", rready_o, 0);
    chk("rst_sel_idx_o", sel_idx_o, 0);
    chk("rst_outstanding_o", outstanding_o, 0);
    chk("rst_full_o", full_o, 0);
    chk("rst_wdog_o", wdog_o, 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    tick();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("rvalid_o", rvalid_o, exp_valid);
      chk("rready_o", rready_o, exp_rready);
      if (exp_valid) chk("sel_idx_o", sel_idx_o, exp_sel);
      chk("outstanding_o", outstanding_o, exp_cnt != 0);
      chk("full_o", full_o, exp_cnt == CNT_MAX);
`ifndef AXI_R_SCHED_WATCHDOG_EN
      chk("wdog_o_off", wdog_o, 0);
`endif
      if (rvalid_o && rready_i) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL beat_unexpected: got beat from input %0d, expected none", sel_idx_o);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat_idx", sel_idx_o, mon_e.idx);
          chk("beat_rid", rid_o, mon_e.b.id);
          chk("beat_aux", aux_o, mon_e.b.aux);
          chk("beat_last", rlast_o, mon_e.b.last);
          got_idx.push_back(int'(sel_idx_o));
        end
      end
    end
  end

  task automatic chk_order(input string name, input int exp_list[$]);
    chk({name, "_count"}, 128'(got_idx.size()), 128'(exp_list.size()));
    for (int i = 0; i < exp_list.size() && i < got_idx.size(); i++)
      chk(name, 128'(got_idx[i]), 128'(exp_list[i]));
  endtask

  logic [ID_W-1:0] held_id;
  logic [AUX_W-1:0] held_aux;
  int guard;

  initial begin
    n_tests = 0; n_fail = 0; mon_en = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_reset();

    // Two single-beat bursts from inputs 1 and 2 after reset: 1 wins first.
    got_idx.delete();
    add_burst(1, 1); add_burst(2, 1);
    repeat (3) step(1, 0, 0);
    chk_order("order_rr", '{1, 2});

    // 4-beat burst on input 0 holds the grant while input 2 waits.
    got_idx.delete();
    add_burst(0, 4); add_burst(2, 1);
    repeat (6) step(1, 0, 0);
    chk_order("order_lock", '{0, 0, 0, 0, 2});

    // Backpressured beat on input 1 stays presented while input 0 raises valid.
    got_idx.delete();
    add_burst(1, 2);
    held_id  = src_q[1][0].id;
    held_aux = src_q[1][0].aux;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) add_burst(0, 1);
      drive(0, 0, 0);
      #1;
      chk("stable_rid", rid_o, held_id);
      chk("stable_aux", aux_o, held_aux);
      chk("stable_sel", sel_idx_o, 1);
      tick();
    end
    repeat (4) step(1, 0, 0);
    chk_order("order_stable", '{1, 1, 0});

    // Outstanding counter: three issues, then three burst ends with one overlapping issue.
    repeat (3) step(0, 0, 1);
    chk("cnt_after_incr", outstanding_o, 1);
    add_burst(0, 1); add_burst(0, 1); add_burst(0, 1);
    step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("cnt_ends_one", outstanding_o, 1);
    chk("cnt_not_full", full_o, 0);

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if (src_q[i].size() < 2 && $urandom_range(3, 0) == 0) add_burst(i, $urandom_range(4, 1));
      step($urandom_range(3, 0) != 0, 1, $urandom_range(3, 0) == 0);
    end
    guard = 0;
    while (guard < 500 && (src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()) > 0) begin
      step(1, 0, 0);
      guard++;
    end
    chk("random_drained", 128'(src_q[0].size() + src_q[1].size() + src_q[2].size() + src_q[3].size()), 0);

    // Reset in the middle of a burst abandons it; arbitration restarts from rr_ptr = N-1.
    add_burst(3, 4);
    repeat (2) step(1, 0, 0);
    do_reset();
    got_idx.delete();
    add_burst(2, 1); add_burst(1, 1);
    repeat (3) step(1, 0, 0);
    chk_order("order_after_rst", '{1, 2});

    // Saturation at all ones and hold under simultaneous issue and burst end.
    do_reset();
    repeat (CNT_MAX + 6) step(0, 0, 1);
    chk("sat_full", full_o, 1);
    add_burst(0, 1);
    step(1, 0, 1);
    chk("sat_hold_full", full_o, 1);
    add_burst(0, 1);
    step(1, 0, 0);
    chk("sat_decr_not_full", full_o, 0);

`ifdef AXI_R_SCHED_WATCHDOG_EN
    do_reset();
    add_burst(0, 2);
    repeat (6) step(0, 0, 0);
    chk("wdog_early", wdog_o, 0);
    repeat (6) step(0, 0, 0);
    chk("wdog_fired", wdog_o, 1);
    repeat (4) step(1, 0, 0);
    chk("wdog_sticky", wdog_o, 1);
`endif

    step(0, 0, 0);
    mon_en = 1'b0;
    chk("exp_q_empty", 128'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
